alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 109 ++++++++++
 tb/tb_alu_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// Command/result sequencer around an external combinational 4-bit ALU.
// Optional feature: define ALU_CTRL_CHAIN_EN to feed the previous result back as operand A.
module alu_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [3:0] in_sel,
    input  logic       in_chain,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic       alu_c,
    input  logic [3:0] alu_out1,
    input  logic [3:0] alu_out2,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_out1,
    output logic [3:0] res_out2,
    output logic       res_c,
    output logic       res_err,
    output logic       busy,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t     state;
    logic       accept;
    logic       div_zero;
    logic [3:0] next_a;

    assign in_ready = (state == IDLE) || ((state == DONE) && res_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign div_zero = (alu_sel == 4'b0011) && (alu_b == '0);

`ifdef ALU_CTRL_CHAIN_EN
    logic [3:0] chain;

    assign next_a = in_chain ? chain : in_a;

    // Chain value is the result being handed over; a same-edge accept still sees the old one.
    always_ff @(posedge clk) begin
        if (rst)
            chain <= '0;
        else if ((state == DONE) && res_ready)
            chain <= res_out1;
    end
`else
    logic unused_chain;

    assign unused_chain = in_chain;
    assign next_a       = in_a;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_out1  <= '0;
            res_out2  <= '0;
            res_c     <= 1'b0;
            res_err   <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            op_count  <= '0;
        end else begin
            if (accept) begin
                alu_a   <= next_a;
                alu_b   <= in_b;
                alu_sel <= in_sel;
            end
            case (state)
                IDLE: begin
                    if (accept)
                        state <= EXEC;
                end
                EXEC: begin
                    if (div_zero) begin
                        res_out1 <= '1;
                        res_out2 <= alu_a;
                        res_c    <= 1'b0;
                        res_err  <= 1'b1;
                    end else begin
                        res_out1 <= alu_out1;
                        res_out2 <= alu_out2;
                        res_c    <= alu_c;
                        res_err  <= 1'b0;
                    end
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                        state     <= in_valid ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Randomized self-checking bench for alu_ctrl with a stub ALU and a transaction-level model.
// Honours ALU_CTRL_CHAIN_EN the same way as the design.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, in_chain;
    logic [3:0] in_a, in_b, in_sel;
    logic [3:0] alu_a, alu_b, alu_sel, alu_out1, alu_out2;
    logic       alu_c;
    logic       res_valid, res_ready, res_c, res_err, busy;
    logic [3:0] res_out1, res_out2;
    logic [7:0] op_count;

    always #5 clk = ~clk;

    alu_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_chain(in_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_c(alu_c), .alu_out1(alu_out1), .alu_out2(alu_out2),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_out1(res_out1), .res_out2(res_out2), .res_c(res_c), .res_err(res_err),
        .busy(busy), .op_count(op_count)
    );

    typedef struct packed {
        logic [3:0] o1;
        logic [3:0] o2;
        logic       c;
        logic       err;
    } res_t;

    // Stub ALU: add, sub, mul, div, then a bitwise mix; div-by-zero returns junk on purpose.
    function automatic res_t alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
        res_t       r;
        logic [4:0] s;
        logic [7:0] p;
        r = '0;
        case (sel)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r.o1 = s[3:0]; r.c = s[4]; end
            4'd1: begin r.o1 = a - b; r.c = (a < b); end
            4'd2: begin p = {4'b0, a} * {4'b0, b}; r.o1 = p[3:0]; r.o2 = p[7:4]; end
            4'd3: begin
                if (b == 4'd0) begin r.o1 = 4'h5; r.o2 = 4'hA; r.c = 1'b1; end
                else begin r.o1 = a / b; r.o2 = a % b; end
            end
            default: begin r.o1 = a ^ b; r.o2 = a & b; r.c = sel[0]; end
        endcase
        return r;
    endfunction

    function automatic res_t ref_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
        res_t r;
        if (sel == 4'd3 && b == 4'd0) begin
            r.o1 = 4'hF; r.o2 = a; r.c = 1'b0; r.err = 1'b1;
        end else begin
            r = alu_fn(a, b, sel);
        end
        return r;
    endfunction

    res_t stub;
    assign stub     = alu_fn(alu_a, alu_b, alu_sel);
    assign alu_out1 = stub.o1;
    assign alu_out2 = stub.o2;
    assign alu_c    = stub.c;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: at most one command in flight, aged in edges since its accept.
    bit         m_pend = 0;
    int         m_age  = 0;
    res_t       m_next = '0, m_res = '0;
    logic [7:0] m_cnt  = '0;
    logic [3:0] m_chain = '0, m_a = '0, m_b = '0, m_sel = '0;

    task automatic cyc(input bit r, input bit v, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] sel, input bit ch, input bit rr, output bit accepted);
        bit         exp_valid, exp_ready, hs;
        logic [3:0] a_eff;
        @(negedge clk);
        rst = r; in_valid = v; in_a = a; in_b = b; in_sel = sel; in_chain = ch; res_ready = rr;
        #1;
        exp_valid = m_pend && (m_age == 2);
        exp_ready = !m_pend || (exp_valid && rr);
        check("in_ready",  in_ready,  exp_ready);
        check("busy",      busy,      m_pend);
        check("res_valid", res_valid, exp_valid);
        check("res_out1",  res_out1,  m_res.o1);
        check("res_out2",  res_out2,  m_res.o2);
        check("res_c",     res_c,     m_res.c);
        check("res_err",   res_err,   m_res.err);
        check("alu_a",     alu_a,     m_a);
        check("alu_b",     alu_b,     m_b);
        check("alu_sel",   alu_sel,   m_sel);
        check("op_count",  op_count,  m_cnt);
        accepted = 0;
        if (r) begin
            m_pend = 0; m_age = 0; m_next = '0; m_res = '0; m_cnt = '0;
            m_chain = '0; m_a = '0; m_b = '0; m_sel = '0;
        end else begin
            hs = exp_valid && rr;
            accepted = v && exp_ready;
`ifdef ALU_CTRL_CHAIN_EN
            a_eff = ch ? m_chain : a;
`else
            a_eff = a;
`endif
            if (hs) begin
                m_cnt++; m_chain = m_res.o1; m_pend = 0;
            end else if (m_pend && m_age == 1) begin
                m_res = m_next; m_age = 2;
            end
            if (accepted) begin
                m_next = ref_fn(a_eff, b, sel);
                m_a = a_eff; m_b = b; m_sel = sel;
                m_pend = 1; m_age = 1;
            end
        end
    endtask

    bit         acc;
    bit         c_v;
    logic [3:0] c_a, c_b, c_sel;
    bit         c_ch;

    initial begin
        rst = 1'b1; in_valid = 0; in_a = '0; in_b = '0; in_sel = '0; in_chain = 0; res_ready = 0;
        repeat (2) @(posedge clk);

        // 9+8 with carry, then mul 7*5, then div by zero
        cyc(0, 1, 4'd9, 4'd8, 4'd0, 0, 1, acc);
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, acc);
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, acc);
        check("add_out1", res_out1, 4'd1);
        check("add_c",    res_c,    1'b1);
        cyc(0, 1, 4'd7, 4'd5, 4'd2, 0, 1, acc);
        check("add_count", op_count, 8'd1);
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, acc);
        // hold result for 5 cycles with a competing command offered
        for (int i = 0; i < 5; i++) cyc(0, 1, 4'd6, 4'd0, 4'd3, 0, 0, acc);
        check("mul_out1", res_out1, 4'd3);
        check("mul_out2", res_out2, 4'd2);
        cyc(0, 1, 4'd6, 4'd0, 4'd3, 0, 1, acc);
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, acc);
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, acc);
        check("div0_out1", res_out1, 4'hF);
        check("div0_out2", res_out2, 4'd6);
        check("div0_err",  res_err,  1'b1);

        // chain: 3+4, then chained +2
        cyc(0, 1, 4'd3, 4'd4, 4'd0, 0, 1, acc);
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, acc);
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, acc);
        cyc(0, 1, 4'd3, 4'd2, 4'd0, 1, 1, acc);
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, acc);
        cyc(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, acc);
`ifdef ALU_CTRL_CHAIN_EN
        check("chain_out1", res_out1, 4'd9);
`else
        check("chain_out1", res_out1, 4'd5);
`endif

        // reset while in EXEC
        cyc(0, 1, 4'd2, 4'd3, 4'd2, 0, 1, acc);
        cyc(1, 0, 4'd0, 4'd0, 4'd0, 0, 1, acc);
        for (int i = 0; i < 3; i++) cyc(0, 0, 4'd0, 4'd0, 4'd0, 0, 1, acc);

        // back-to-back stream long enough to wrap op_count
        for (int i = 0; i < 600; i++)
            cyc(0, 1, 4'($urandom), 4'($urandom), 4'($urandom_range(0, 5)), 1'($urandom), 1, acc);

        // random traffic with source holding commands until accepted
        c_v = 0; c_a = '0; c_b = '0; c_sel = '0; c_ch = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!c_v && ($urandom % 3 != 0)) begin
                c_v   = 1;
                c_a   = 4'($urandom);
                c_b   = ($urandom % 4 == 0) ? 4'd0 : 4'($urandom);
                c_sel = ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
                c_ch  = 1'($urandom);
            end
            cyc(($urandom % 97 == 0), c_v, c_a, c_b, c_sel, c_ch, ($urandom % 4 != 0), acc);
            if (acc || rst) c_v = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
